ca_generation_engine: RTL and testbench

- Parametrised next-generation cellular-automaton engine for bit-packed grids held in a double-buffered (ping-pong) pair of external RAM banks.
- On each start request it sweeps the current source bank once and writes one generation into the other bank.
- At frame end it swaps banks and exposes the completed bank to the VGA path.
- Adds run-time rule masks (any outer-totalistic B/S rule), toroidal or dead-border edges, a start/busy/done handshake and a generation counter.

---
 rtl/ca_generation_engine.sv | 138 +++++++++++++
 tb/tb_ca_generation_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_generation_engine.sv
// ca_generation_engine: sweeps the source bank once per start and writes the next outer-totalistic CA generation into the other bank
module ca_generation_engine #(
    parameter int WORD_W        = 20,
    parameter int WORDS_PER_ROW = 64,
    parameter int ROWS          = 1024,
    parameter int ADDR_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        birth_mask,
    input  logic [8:0]        survive_mask,
    input  logic              wrap,
    output logic              busy,
    output logic              done,
    output logic              src_bank,
    output logic [15:0]       gen_count,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [WORD_W-1:0] rd_q,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_en
);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(WORDS_PER_ROW + 2);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(WORDS_PER_ROW + 1);
    localparam logic [ADDR_W-1:0] WPR_A = ADDR_W'(WORDS_PER_ROW);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [RW-1:0] row, row_d, frow;
    logic [SW-1:0] slot, slot_d, fcol;
    logic [1:0] ph, ph_d;
    logic vld_d, inj_d, drain_q, wrap_q, row_edge, col_edge, inject, last, emit;
    logic [8:0] birth_q, surv_q;
    logic [3*WORD_W-1:0] win [3];
    logic [3*WORD_W-1:0] top, mid, bot;
    logic [WORD_W-1:0] word, nxt;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SWEEP;
            SWEEP:   if (last) state_nx = DRAIN;
            DRAIN:   if (drain_q) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // phase 0/1/2 fetches rows r-1/r/r+1 at column slot-1; out-of-grid words wrap or read as zero
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        row_edge = (ph == 2'd0 && row == '0) || (ph == 2'd2 && row == R_LAST);
        col_edge = slot == '0 || slot == S_LAST;
        frow = ph == 2'd0 ? (row == '0 ? R_LAST : row - 1'b1) :
               ph == 2'd1 ? row : (row == R_LAST ? '0 : row + 1'b1);
        fcol = slot == '0 ? SW'(WORDS_PER_ROW - 1) : slot == S_LAST ? '0 : slot - 1'b1;
        inject = (row_edge || col_edge) && !wrap_q;
        last = row == R_LAST && slot == S_LAST && ph == 2'd2;
        rd_en = state == SWEEP && !inject;
        rd_addr = rd_en ? ADDR_W'(frow) * WPR_A + ADDR_W'(fcol) : '0;
        word = inj_d ? '0 : rd_q;
        emit = vld_d && ph_d == 2'd2 && slot_d >= SW'(2);
        top = win[0];
        mid = win[1];
        bot = {win[2][2*WORD_W-1:0], word};
    end

    // bottom row is taken straight from the arriving word so the write issues one cycle after the last fetch returns
    for (genvar i = 0; i < WORD_W; i++) begin : g_cell
        logic [3:0] n;
        assign n = 4'(top[WORD_W+i+1]) + 4'(top[WORD_W+i]) + 4'(top[WORD_W+i-1]) +
                   4'(mid[WORD_W+i+1]) + 4'(mid[WORD_W+i-1]) +
                   4'(bot[WORD_W+i+1]) + 4'(bot[WORD_W+i]) + 4'(bot[WORD_W+i-1]);
        assign nxt[i] = mid[WORD_W+i] ? surv_q[n] : birth_q[n];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            row <= '0;
            slot <= '0;
            ph <= '0;
            drain_q <= 1'b0;
            wrap_q <= 1'b0;
            birth_q <= '0;
            surv_q <= '0;
            src_bank <= 1'b0;
            gen_count <= '0;
            vld_d <= 1'b0;
            inj_d <= 1'b0;
            ph_d <= '0;
            slot_d <= '0;
            row_d <= '0;
            win <= '{default: '0};
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                wrap_q <= wrap;
                birth_q <= birth_mask;
                surv_q <= survive_mask;
                row <= '0;
                slot <= '0;
                ph <= '0;
            end
            if (state == SWEEP) begin
                ph <= ph == 2'd2 ? 2'd0 : ph + 1'b1;
                if (ph == 2'd2) begin
                    slot <= slot == S_LAST ? '0 : slot + 1'b1;
                    if (slot == S_LAST) row <= row == R_LAST ? '0 : row + 1'b1;
                end
            end
            drain_q <= state == DRAIN && !drain_q;
            if (state == DRAIN && drain_q) begin
                src_bank <= ~src_bank;
                gen_count <= gen_count + 1'b1;
            end
            vld_d <= state == SWEEP;
            inj_d <= inject;
            ph_d <= ph;
            slot_d <= slot;
            row_d <= row;
            if (vld_d) win[ph_d] <= {win[ph_d][2*WORD_W-1:0], word};
            wr_en <= emit;
            if (emit) begin
                wr_addr <= ADDR_W'(row_d) * WPR_A + ADDR_W'(slot_d - SW'(2));
                wr_data <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_ca_generation_engine.sv
// tb_ca_generation_engine: directed checks of the CA engine on an 8x32 grid against hand-computed patterns
module tb_ca_generation_engine;
    localparam int W = 8, WPR = 4, R = 8, AW = 5;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, wrap = 1'b1;
    logic [8:0] birth_mask = 9'h008, survive_mask = 9'h00C;
    logic busy, done, src_bank, rd_en, wr_en;
    logic [15:0] gen_count;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0] rd_q, wr_data;

    logic [W-1:0] mem [2][32];
    logic ld_en = 1'b0, ld_bank = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0] ld_data = '0;
    int wr_cnt = 0, ord_bad = 0, done_cnt = 0;
    int total = 0, bad = 0;
    logic cur = 1'b0;
    logic [31:0] pat [R];
    logic [31:0] expr [R];

    always #5 clk = ~clk;

    ca_generation_engine #(.WORD_W(W), .WORDS_PER_ROW(WPR), .ROWS(R), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .wrap(wrap), .busy(busy), .done(done),
        .src_bank(src_bank), .gen_count(gen_count), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_q(rd_q), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
    );

    // two-bank RAM with 1-cycle read latency, plus write-order and done-pulse tracking
    always @(posedge clk) begin
        if (rd_en) rd_q <= mem[src_bank][rd_addr];
        if (wr_en) mem[~src_bank][wr_addr] <= wr_data;
        if (ld_en) mem[ld_bank][ld_addr] <= ld_data;
        if (start && !busy) wr_cnt <= 0;
        else if (wr_en) begin
            if (wr_addr != AW'(wr_cnt)) ord_bad <= ord_bad + 1;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rowv(input logic b, input int r);
        rowv = {mem[b][AW'(4*r)], mem[b][AW'(4*r+1)], mem[b][AW'(4*r+2)], mem[b][AW'(4*r+3)]};
    endfunction

    task automatic load(input logic b);
        for (int r = 0; r < R; r++)
            for (int w = 0; w < WPR; w++) begin
                @(negedge clk);
                ld_en = 1'b1;
                ld_bank = b;
                ld_addr = AW'(r*WPR + w);
                ld_data = W'(pat[r] >> (24 - 8*w));
            end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_grid(input string tag);
        for (int r = 0; r < R; r++) chk($sformatf("%s row%0d", tag, r), rowv(cur, r), expr[r]);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " flags"}, 32'({busy, done, src_bank, rd_en, wr_en}), 32'h0);
        chk({tag, " gen_count"}, 32'(gen_count), 32'h0);
        chk({tag, " addrs"}, 32'({rd_addr, wr_addr}), 32'h0);
        chk({tag, " wr_data"}, 32'(wr_data), 32'h0);
    endtask

    task automatic start_gen();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // done must appear within 3*R*(WPR+2)+6 cycles of acceptance
    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 150 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        chk({tag, " done seen"}, 32'(seen), 32'h1);
        cur = ~cur;
    endtask

    task automatic run_gen(input int n, input string tag);
        int d0, o0;
        d0 = done_cnt;
        o0 = ord_bad;
        for (int g = 0; g < n; g++) begin
            start_gen();
            wait_done(tag);
        end
        @(negedge clk);
        chk({tag, " done pulses"}, 32'(done_cnt - d0), 32'(n));
        chk({tag, " writes"}, 32'(wr_cnt), 32'd32);
        chk({tag, " order"}, 32'(ord_bad - o0), 32'h0);
        chk({tag, " src_bank"}, 32'(src_bank), 32'(cur));
    endtask

    initial begin
        int d0, noise;
        logic seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("reset");

        pat = '{default: 32'h0};
        pat[3] = 32'h0020_0000;
        pat[4] = 32'h0020_0000;
        pat[5] = 32'h0020_0000;
        load(cur);
        run_gen(1, "blinker g1");
        expr = '{default: 32'h0};
        expr[4] = 32'h0070_0000;
        check_grid("blinker g1");
        chk("blinker g1 bank", 32'(src_bank), 32'h1);
        chk("blinker g1 gen", 32'(gen_count), 32'd1);
        run_gen(1, "blinker g2");
        expr = pat;
        check_grid("blinker g2");
        chk("blinker g2 gen", 32'(gen_count), 32'd2);

        pat = '{default: 32'h0};
        pat[4] = 32'h01C0_0000;
        load(cur);
        run_gen(1, "word edge");
        expr = '{default: 32'h0};
        expr[3] = 32'h0080_0000;
        expr[4] = 32'h0080_0000;
        expr[5] = 32'h0080_0000;
        check_grid("word edge");

        pat = '{default: 32'h0};
        pat[2] = 32'h0070_0000;
        pat[4] = 32'h0070_0000;
        load(cur);
        birth_mask = 9'h048;
        start_gen();
        repeat (40) @(negedge clk);
        birth_mask = 9'h008;
        survive_mask = 9'h000;
        wrap = 1'b0;
        wait_done("highlife");
        @(negedge clk);
        expr = '{default: 32'h0};
        for (int r = 1; r <= 5; r++) expr[r] = 32'h0020_0000;
        check_grid("highlife");
        survive_mask = 9'h00C;
        wrap = 1'b1;
        load(cur);
        run_gen(1, "life b3s23");
        expr[3] = 32'h0;
        check_grid("life b3s23");

        pat = '{default: 32'h0};
        pat[1] = 32'h2000_0000;
        pat[2] = 32'h1000_0000;
        pat[3] = 32'h7000_0000;
        load(cur);
        run_gen(32, "glider wrap");
        expr = '{default: 32'h0};
        expr[1] = 32'h0020_0000;
        expr[2] = 32'h0010_0000;
        expr[3] = 32'h0070_0000;
        check_grid("glider wrap");

        pat = '{default: 32'h0};
        pat[5] = 32'h0000_0002;
        pat[6] = 32'h0000_0001;
        pat[7] = 32'h0000_0007;
        load(cur);
        wrap = 1'b0;
        run_gen(4, "glider border");
        expr = '{default: 32'h0};
        expr[6] = 32'h0000_0003;
        expr[7] = 32'h0000_0003;
        check_grid("glider border");
        wrap = 1'b1;

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur = 1'b0;
        pat = '{default: 32'h0};
        pat[3] = 32'h0020_0000;
        pat[4] = 32'h0020_0000;
        pat[5] = 32'h0020_0000;
        load(cur);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 150 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        start = 1'b0;
        chk("held start done seen", 32'(seen), 32'h1);
        cur = ~cur;
        noise = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) noise++;
        end
        chk("held start single gen", 32'(noise), 32'h0);
        chk("held start done pulses", 32'(done_cnt - d0), 32'd1);
        chk("held start gen", 32'(gen_count), 32'd1);
        expr = '{default: 32'h0};
        expr[4] = 32'h0070_0000;
        check_grid("held start");

        d0 = done_cnt;
        start_gen();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy start");
        noise = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) noise++;
        end
        chk("busy start ignored", 32'(noise), 32'h0);
        chk("busy start done pulses", 32'(done_cnt - d0), 32'd1);
        chk("busy start gen", 32'(gen_count), 32'd2);
        expr = pat;
        check_grid("busy start");

        run_gen(1, "pre reset");
        chk("pre reset bank", 32'(src_bank), 32'h1);
        start_gen();
        repeat (75) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset("async reset");
        @(negedge clk);
        reset = 1'b0;
        cur = 1'b0;
        noise = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en || wr_en || busy) noise++;
        end
        chk("quiet after reset", 32'(noise), 32'h0);
        load(cur);
        run_gen(1, "post reset");
        expr = '{default: 32'h0};
        expr[4] = 32'h0070_0000;
        check_grid("post reset");
        chk("post reset bank", 32'(src_bank), 32'h1);
        chk("post reset gen", 32'(gen_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
